// File: rtl/lut_loader_pkg.sv
// rtl/lut_loader_pkg.sv - shared types and constants for the LUT coefficient loader
package lut_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READ,
        DRAIN,
        DONE
    } state_t;

    localparam int LUT_RD_LATENCY = 2;
    localparam int CHECKSUM_W     = 32;

endpackage

// File: rtl/lut_rd_valid_pipe.sv
// rtl/lut_rd_valid_pipe.sv - shift register tracking which LUT read data is valid
module lut_rd_valid_pipe
    import lut_loader_pkg::*;
#(
    parameter int LATENCY = LUT_RD_LATENCY
) (
    input  logic clock,
    input  logic rst,
    input  logic rden,
    output logic valid
);

    logic [LATENCY-1:0] stage;

    always_ff @(posedge clock) begin
        if (rst) begin
            stage <= '0;
        end else begin
            stage <= (stage << 1) | LATENCY'(rden);
        end
    end

    assign valid = stage[LATENCY-1];

endmodule

// File: rtl/lut_coeff_loader.sv
// rtl/lut_coeff_loader.sv - streams coefficients into a LUT RAM and verifies them by checksum readback
module lut_coeff_loader
    import lut_loader_pkg::*;
#(
    parameter int DEPTH      = 3072,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] lut_address,
    output logic [31:0]           lut_data,
    output logic                  lut_wren,
    output logic                  lut_rden,
    input  logic [31:0]           lut_q,
    output logic                  busy,
    output logic                  done,
    output logic                  match,
    output logic [31:0]           checksum
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                  state;
    state_t                  next_state;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [CHECKSUM_W-1:0]   wsum;
    logic [CHECKSUM_W-1:0]   rsum;
    logic                    drain_cnt;
    logic                    start_ok;
    logic                    handshake;
    logic                    rd_valid;

    assign start_ok  = start && (state == IDLE || state == DONE);
    assign handshake = in_valid && (state == LOAD);

    always_ff @(posedge clock) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    if (handshake && wr_addr == LAST_ADDR) next_state = READ;
            READ:    if (rd_addr == LAST_ADDR) next_state = DRAIN;
            DRAIN:   if (drain_cnt) next_state = DONE;
            DONE:    if (start) next_state = LOAD;
            default: next_state = IDLE;
        endcase
    end

    // Readback sum only sees words that actually came out of the LUT pipeline.
    always_ff @(posedge clock) begin
        if (rst || start_ok) begin
            wr_addr   <= '0;
            rd_addr   <= '0;
            wsum      <= '0;
            rsum      <= '0;
            drain_cnt <= 1'b0;
        end else begin
            if (handshake) begin
                wr_addr <= wr_addr + 1'b1;
                wsum    <= wsum + in_data;
            end
            if (state == READ) begin
                rd_addr <= rd_addr + 1'b1;
            end
            if (state == DRAIN) begin
                drain_cnt <= 1'b1;
            end
            if (rd_valid) begin
                rsum <= rsum + lut_q;
            end
        end
    end

    lut_rd_valid_pipe #(
        .LATENCY (LUT_RD_LATENCY)
    ) u_rd_valid_pipe (
        .clock (clock),
        .rst   (rst),
        .rden  (lut_rden),
        .valid (rd_valid)
    );

    always_comb begin
        in_ready    = 1'b0;
        lut_wren    = 1'b0;
        lut_rden    = 1'b0;
        lut_address = '0;
        lut_data    = '0;
        busy        = 1'b0;
        done        = 1'b0;
        match       = 1'b0;
        checksum    = wsum;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                lut_wren = handshake;
                if (handshake) begin
                    lut_address = wr_addr;
                    lut_data    = in_data;
                end
            end
            READ: begin
                busy        = 1'b1;
                lut_rden    = 1'b1;
                lut_address = rd_addr;
            end
            DRAIN: begin
                busy = 1'b1;
            end
            DONE: begin
                done  = 1'b1;
                match = (wsum == rsum);
            end
            default: begin
                checksum = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_lut_coeff_loader.sv
// tb/tb_lut_coeff_loader.sv - directed self-checking bench for lut_coeff_loader
module tb_lut_coeff_loader;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  lut_address;
    logic [31:0] lut_data;
    logic        lut_wren;
    logic        lut_rden;
    logic [31:0] lut_q;
    logic        busy;
    logic        done;
    logic        match;
    logic [31:0] checksum;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [8];
    logic [2:0]  addr_r = '0;
    logic [31:0] q_r = '0;
    logic        corrupt = 1'b0;
    logic [31:0] words [8];

    int done_cyc;
    int gap_wren;
    int addr_err;
    int overlap;

    always #5 clock = ~clock;

    lut_coeff_loader #(
        .DEPTH      (8),
        .ADDR_WIDTH (3)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .start       (start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .lut_address (lut_address),
        .lut_data    (lut_data),
        .lut_wren    (lut_wren),
        .lut_rden    (lut_rden),
        .lut_q       (lut_q),
        .busy        (busy),
        .done        (done),
        .match       (match),
        .checksum    (checksum)
    );

    // Behavioural LUT: registered address, registered output, optional fault at address 5.
    always @(posedge clock) begin
        if (lut_wren) mem[lut_address] <= lut_data;
        addr_r <= lut_address;
        q_r    <= mem[addr_r] + ((corrupt && addr_r == 3'd5) ? 32'd1 : 32'd0);
    end
    assign lut_q = q_r;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic all_zero(input string tag);
        chk(tag, {32'(lut_address), lut_data[31:0]}, 64'd0);
        chk(tag, {checksum, 25'd0, in_ready, lut_wren, lut_rden, busy, done, match, 1'b0}, 64'd0);
    endtask

    task automatic run(input int gap_after, input int gap_len, input bit glitch, input int rst_at);
        int cyc;
        int k;
        int gapc;
        bit in_gap;
        @(negedge clock);
        start    = 1'b1;
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        start    = 1'b0;
        cyc      = 1;
        k        = 0;
        gapc     = 0;
        gap_wren = 0;
        addr_err = 0;
        overlap  = 0;
        chk("first_cycle_busy_done", {busy, done}, 2'b10);
        while (!done && cyc < 200) begin
            in_gap = 1'b0;
            start  = glitch && (cyc == 3 || cyc == 12);
            if (rst_at == cyc) begin
                rst = 1'b1;
                @(posedge clock);
                #1;
                rst = 1'b0;
                all_zero("after_rst");
                done_cyc = -1;
                return;
            end
            if (in_ready) begin
                if (k == gap_after && gapc < gap_len) begin
                    in_valid = 1'b0;
                    in_gap   = 1'b1;
                    gapc++;
                end else begin
                    in_valid = 1'b1;
                    in_data  = words[k];
                end
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_gap && lut_wren) gap_wren++;
            if (lut_wren && (lut_address !== 3'(k) || lut_data !== words[k])) addr_err++;
            if (lut_wren && lut_rden) overlap++;
            if (in_valid && in_ready) k++;
            @(posedge clock);
            #1;
            cyc++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        done_cyc = cyc;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        all_zero("reset_state");
        rst = 1'b0;
        @(posedge clock);
        #1;
        all_zero("idle_state");

        for (int i = 0; i < 8; i++) words[i] = 32'(i + 1);
        run(-1, 0, 1'b0, -1);
        chk("t1_done_cyc", 64'(done_cyc), 64'd19);
        chk("t1_checksum", checksum, 32'd36);
        chk("t1_match", match, 1'b1);
        chk("t1_wr_addr_data", 64'(addr_err), 64'd0);
        chk("t1_wren_rden_overlap", 64'(overlap), 64'd0);
        chk("t1_busy", busy, 1'b0);

        run(4, 3, 1'b0, -1);
        chk("t2_done_cyc", 64'(done_cyc), 64'd22);
        chk("t2_gap_wren", 64'(gap_wren), 64'd0);
        chk("t2_checksum", checksum, 32'd36);
        chk("t2_match", match, 1'b1);
        chk("t2_wr_addr_data", 64'(addr_err), 64'd0);

        corrupt = 1'b1;
        run(-1, 0, 1'b0, -1);
        chk("t3_done_cyc", 64'(done_cyc), 64'd19);
        chk("t3_checksum", checksum, 32'd36);
        chk("t3_match", match, 1'b0);
        corrupt = 1'b0;

        for (int i = 0; i < 8; i++) words[i] = 32'hFFFF_FFFF;
        run(-1, 0, 1'b0, -1);
        chk("t4_checksum_wrap", checksum, 32'hFFFF_FFF8);
        chk("t4_match", match, 1'b1);

        for (int i = 0; i < 8; i++) words[i] = 32'h1000_0000 + 32'(i * 3);
        run(-1, 0, 1'b1, -1);
        chk("t5_done_cyc", 64'(done_cyc), 64'd19);
        chk("t5_checksum", checksum, 32'h8000_0054);
        chk("t5_match", match, 1'b1);

        for (int i = 0; i < 8; i++) words[i] = 32'(i + 1);
        run(-1, 0, 1'b0, 11);
        chk("t6_rst_abort", 64'(done_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
        run(-1, 0, 1'b0, -1);
        chk("t6_done_cyc", 64'(done_cyc), 64'd19);
        chk("t6_checksum", checksum, 32'd36);
        chk("t6_match", match, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
